backprop_delta: RTL and testbench

Backward-pass counterpart of the forward activation stage. It takes each neuron's activation output and its training target, then computes the error-scaled, learning-rate-scaled gradient term delta = LEARN_RATE × (target − prediction) × f′. The derivative f′ is selected per sample from the same `act_func` encoding used in the forward path. The block sits between the forward prediction stage and the weight-update logic as a 2-stage valid/ready pipeline, with an optional per-batch mean-squared-error monitor.

---
 rtl/backprop_delta.sv | 151 +++++++++++++++
 tb/tb_backprop_delta.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backprop_delta.sv
// Backward-pass delta stage: delta = LEARN_RATE * (target - prediction) * f'(prediction).
// Two-stage valid/ready pipeline; optional per-batch MSE monitor built with BACKPROP_LOSS_EN.
package backprop_delta_pkg;
  typedef enum logic [2:0] {
    ACT_SIGMOID = 3'd0,
    ACT_TANH    = 3'd1,
    ACT_RELU    = 3'd2,
    ACT_STEP    = 3'd3,
    ACT_LINEAR  = 3'd4
  } act_func;
endpackage

module backprop_delta
  import backprop_delta_pkg::*;
#(
  parameter real         LEARN_RATE = 0.5,
  parameter int unsigned BATCH      = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  act_func activation,
  input  logic    in_valid,
  output logic    in_ready,
  input  real     prediction,
  input  real     target,
  output logic    out_valid,
  input  logic    out_ready,
  output real     delta
`ifdef BACKPROP_LOSS_EN
  ,
  output logic    loss_valid,
  output real     loss
`endif
);

  if (BATCH < 1) begin : g_batch_chk
    $error("backprop_delta: BATCH must be at least 1");
  end

  logic run;
  logic s1_valid;
  real  s1_err;
  real  s1_deriv;
  real  deriv;
  logic s1_accept;
  logic s2_accept;
  logic in_fire;
  logic out_fire;

  // Handshake: backpressure ripples combinationally so a full pipe still moves 1/clk.
  assign s2_accept = !out_valid || out_ready;
  assign s1_accept = !s1_valid || s2_accept;
  assign in_ready  = run && s1_accept;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Derivative evaluated from the activation output, not the pre-activation sum.
  always_comb begin
    deriv = 1.0;
    case (activation)
      ACT_SIGMOID: deriv = prediction * (1.0 - prediction);
      ACT_TANH:    deriv = 1.0 - prediction * prediction;
      ACT_RELU:    deriv = (prediction > 0.0) ? 1.0 : 0.0;
      ACT_STEP:    deriv = 1.0;
      default:     deriv = 1.0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 0.0;
      s1_deriv <= 0.0;
    end else if (s1_accept) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_err   <= target - prediction;
        s1_deriv <= deriv;
      end
    end
  end

`ifdef BACKPROP_LOSS_EN
  real s2_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      delta     <= 0.0;
      s2_err    <= 0.0;
    end else if (s2_accept) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        delta  <= LEARN_RATE * s1_err * s1_deriv;
        s2_err <= s1_err;
      end
    end
  end

  localparam int unsigned CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;

  logic [CNT_W-1:0] cnt;
  real              acc;
  real              err_sq;

  assign err_sq = s2_err * s2_err;

  // Only consumed outputs contribute; the batch closes on the BATCH-th handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 0.0;
      cnt        <= '0;
      loss       <= 0.0;
      loss_valid <= 1'b0;
    end else begin
      loss_valid <= 1'b0;
      if (out_fire) begin
        if (cnt == CNT_W'(BATCH - 1)) begin
          loss       <= (acc + err_sq) / real'(BATCH);
          loss_valid <= 1'b1;
          acc        <= 0.0;
          cnt        <= '0;
        end else begin
          acc <= acc + err_sq;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      delta     <= 0.0;
    end else if (s2_accept) begin
      out_valid <= s1_valid;
      if (s1_valid) delta <= LEARN_RATE * s1_err * s1_deriv;
    end
  end

  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_backprop_delta.sv
// Self-checking bench for backprop_delta: directed spec cases plus randomized traffic
// scored against a behavioural model of the delta and per-batch loss rules.
module tb_backprop_delta;
  import backprop_delta_pkg::*;

  localparam int unsigned BATCH = 4;
  localparam real         LR    = 0.5;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  act_func activation = ACT_LINEAR;
  logic    in_valid = 1'b0;
  logic    in_ready;
  real     prediction = 0.0;
  real     target = 0.0;
  logic    out_valid;
  logic    out_ready = 1'b0;
  real     delta;
`ifdef BACKPROP_LOSS_EN
  logic    loss_valid;
  real     loss;
`endif

  int n_checks = 0;
  int n_pass = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  backprop_delta #(.LEARN_RATE(LR), .BATCH(BATCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .activation (activation),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .prediction (prediction),
    .target     (target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .delta      (delta)
`ifdef BACKPROP_LOSS_EN
    ,
    .loss_valid (loss_valid),
    .loss       (loss)
`endif
  );

  task automatic check(input string tag, input real got, input real exp);
    real diff;
    diff = got - exp;
    if (diff < 0.0) diff = -diff;
    n_checks++;
    if (diff > 1e-9) $display("FAIL %s: got %f expected %f", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic real ref_deriv(input act_func a, input real p);
    case (a)
      ACT_SIGMOID: return p * (1.0 - p);
      ACT_TANH:    return 1.0 - p * p;
      ACT_RELU:    return (p > 0.0) ? 1.0 : 0.0;
      default:     return 1.0;
    endcase
  endfunction

  typedef struct {
    real d;
    real e;
  } exp_t;

  exp_t q[$];
  real  seen[$];
  bit   held = 1'b0;
  real  held_delta = 0.0;
  real  m_acc = 0.0;
  int   m_cnt = 0;
  bit   loss_due = 1'b0;
  real  loss_exp = 0.0;
  int   loss_pulses = 0;
  real  last_loss = 0.0;

  // Scoreboard: observes both handshakes away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      m_acc = 0.0;
      m_cnt = 0;
      loss_due = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", out_valid, 1.0);
        check("stall_delta", delta, held_delta);
      end
`ifdef BACKPROP_LOSS_EN
      check("loss_valid", loss_valid, loss_due);
      if (loss_due) check("loss", loss, loss_exp);
      if (loss_valid) begin
        loss_pulses++;
        last_loss = loss;
      end
`endif
      loss_due = 1'b0;
      if (out_valid && out_ready) begin
        seen.push_back(delta);
        if (q.size() == 0) begin
          check("spurious_out", 1.0, 0.0);
        end else begin
          e = q.pop_front();
          check("delta", delta, e.d);
          m_acc += e.e * e.e;
          m_cnt++;
          if (m_cnt == BATCH) begin
            loss_due = 1'b1;
            loss_exp = m_acc / real'(BATCH);
            m_acc = 0.0;
            m_cnt = 0;
          end
        end
      end
      held = out_valid && !out_ready;
      held_delta = delta;
      if (in_valid && in_ready) begin
        e.e = target - prediction;
        e.d = LR * e.e * ref_deriv(activation, prediction);
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input act_func a, input real p, input real t);
    bit ok;
    int n;
    activation = a;
    prediction = p;
    target = t;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 0.0, 1.0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_mode = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", real'(q.size()), 0.0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0.0);
    check("rst_out_valid", out_valid, 0.0);
    check("rst_delta", delta, 0.0);
`ifdef BACKPROP_LOSS_EN
    check("rst_loss_valid", loss_valid, 0.0);
    check("rst_loss", loss, 0.0);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst_release_ready", in_ready, 1.0);
  endtask

  initial begin
    real exp_tab[4];
    real p;
    real t;
    int  pulses0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Sigmoid latency: handshake cycle c, out_valid visible in cycle c+2.
    activation = ACT_SIGMOID;
    prediction = 0.75;
    target = 1.0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_after_accept", out_valid, 0.0);
    @(posedge clk);
    #1;
    check("lat_out_valid", out_valid, 1.0);
    check("sigmoid_delta", delta, 0.0234375);
    drain();

    // Per-sample activation switching and boundaries, back to back.
    seen.delete();
    send(ACT_TANH, 0.5, 0.0);
    send(ACT_RELU, 0.0, 1.0);
    send(ACT_RELU, 2.0, 3.0);
    send(ACT_STEP, 1.0, 0.0);
    drain();
    exp_tab[0] = -0.1875;
    exp_tab[1] = 0.0;
    exp_tab[2] = 0.5;
    exp_tab[3] = -0.5;
    check("dir_count", real'(seen.size()), 4.0);
    for (int i = 0; i < 4 && i < seen.size(); i++) check("dir_delta", seen[i], exp_tab[i]);

    // Backpressure: two accepts fill the pipe, then in_ready stays low.
    seen.delete();
    out_ready = 1'b0;
    send(ACT_LINEAR, 0.0, 1.0);
    send(ACT_LINEAR, 0.0, 2.0);
    activation = ACT_LINEAR;
    prediction = 0.0;
    target = 3.0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0.0);
      tick();
    end
    out_ready = 1'b1;
    send(ACT_LINEAR, 0.0, 3.0);
    send(ACT_LINEAR, 0.0, 4.0);
    send(ACT_LINEAR, 0.0, 5.0);
    drain();
    check("bp_count", real'(seen.size()), 5.0);
    for (int i = 0; i < 5 && i < seen.size(); i++) check("bp_order", seen[i], 0.5 * real'(i + 1));

    // Randomized traffic with random idles and random downstream stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      p = real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
      t = real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
      send(act_func'(3'($urandom_range(0, 4))), p, t);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    // Reset with a partial batch in flight, then clean batches.
    do_reset();
    send(ACT_LINEAR, 0.0, 3.0);
    send(ACT_LINEAR, 0.0, 3.0);
    do_reset();
    pulses0 = loss_pulses;
    for (int i = 0; i < 4; i++) send(ACT_LINEAR, 1.0, 2.0);
    drain();
`ifdef BACKPROP_LOSS_EN
    check("batch1_pulses", real'(loss_pulses - pulses0), 1.0);
    check("batch1_loss", last_loss, 1.0);
`endif
    send(ACT_LINEAR, 0.0, 1.0);
    send(ACT_LINEAR, 1.0, 0.0);
    send(ACT_LINEAR, 0.0, 2.0);
    send(ACT_LINEAR, 3.0, 3.0);
    drain();
`ifdef BACKPROP_LOSS_EN
    check("batch2_pulses", real'(loss_pulses - pulses0), 2.0);
    check("batch2_loss", last_loss, 1.5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
